// File: rtl/serial_alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer: op codes, FSM state encodings
// and the two fixed count values that carry meaning for the ALU.
package serial_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_QSEL = 4'd2;
  localparam logic [3:0] OP_RELU = 4'd10;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] PRE  = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // count 0 clears the ALU carry; count 1 is the sign-peek cycle
  localparam int CNT_CLR  = 0;
  localparam int CNT_SIGN = 1;

endpackage

// File: rtl/serial_operand_shifter.sv
// Parallel-load, LSB-first operand shift register with an MSB peek used
// by the sequencer's sign cycle.
module serial_operand_shifter #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [LENGTH-1:0] data,
  output logic              lsb,
  output logic              msb
);

  logic [LENGTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {1'b0, sr[LENGTH-1:1]};
    end
  end

  assign lsb = sr[0];
  assign msb = sr[LENGTH-1];

endmodule

// File: rtl/serial_alu_sequencer.sv
// Sequences one bit-serial ALU operation: IDLE -> CLR -> PRE -> RUN -> DONE.
// Optional SEQ_ZERO_FLAG_EN adds rsp_zero, high when every captured result bit is 0.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [1:0]        req_q,
  input  logic [LENGTH-1:0] req_rs1,
  input  logic [LENGTH-1:0] req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LENGTH-1:0] rsp_rd,
  output logic              alu_rs1_d,
  output logic              alu_rs2_d,
  output logic [3:0]        alu_op,
  output logic [1:0]        alu_q,
  output logic [CNT_W-1:0]  count,
  output logic              reg_write,
`ifdef SEQ_ZERO_FLAG_EN
  output logic              rsp_zero,
`endif
  input  logic              alu_rd_d
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH + 1);

  logic [2:0]        state;
  logic [LENGTH-1:0] result;
  logic              accept;
  logic              rs1_lsb, rs1_msb, rs2_lsb, rs2_msb;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign reg_write = (state == RUN);
  assign accept    = req_valid && req_ready;
  assign rsp_rd    = result;

  serial_operand_shifter #(.LENGTH(LENGTH)) u_rs1 (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == RUN),
    .data  (req_rs1),
    .lsb   (rs1_lsb),
    .msb   (rs1_msb)
  );

  serial_operand_shifter #(.LENGTH(LENGTH)) u_rs2 (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == RUN),
    .data  (req_rs2),
    .lsb   (rs2_lsb),
    .msb   (rs2_msb)
  );

  // PRE exposes the sign bits; RUN streams operands LSB-first
  always_comb begin
    alu_rs1_d = 1'b0;
    alu_rs2_d = 1'b0;
    if (state == PRE) begin
      alu_rs1_d = rs1_msb;
      alu_rs2_d = rs2_msb;
    end else if (state == RUN) begin
      alu_rs1_d = rs1_lsb;
      alu_rs2_d = rs2_lsb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CLR;
            count <= CNT_W'(CNT_CLR);
          end
        end
        CLR: begin
          state <= PRE;
          count <= CNT_W'(CNT_SIGN);
        end
        PRE: begin
          state <= RUN;
          count <= count + 1'b1;
        end
        RUN: begin
          // count stays at LENGTH+1 through DONE
          if (count == CNT_LAST) begin
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op <= '0;
      alu_q  <= '0;
    end else if (accept) begin
      alu_op <= req_op;
      alu_q  <= req_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else if (state == RUN) begin
      result <= {alu_rd_d, result[LENGTH-1:1]};
    end
  end

`ifdef SEQ_ZERO_FLAG_EN
  logic any_one;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_one <= 1'b0;
    end else if (state == CLR) begin
      any_one <= 1'b0;
    end else if (state == RUN) begin
      any_one <= any_one | alu_rd_d;
    end
  end

  assign rsp_zero = rsp_valid && !any_one;
`endif

endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
- Sequences one bit-serial ALU operation end to end: accepts a parallel request, streams operand bits LSB-first to the serialized ALU, drives its count/reg_write/op/Q controls, collects the serial result and returns it in parallel.
- Sits between the core's execute-stage controller (request/response handshakes) and the bit-sliced ALU datapath.
- Exactly one operation in flight at a time.

Parameters:
- LENGTH, 32, operand/result width in bits; legal range 2..64, so the highest issued count, LENGTH+1, stays below 66.
- CNT_W, 8, width of the count bus driven to the ALU.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  ALU op code (0 add, 1 sub-path, 2 Q-dependent, 10 sign-gated pass).
- req_q  in  2  Q mode for the op.
- req_rs1  in  LENGTH  operand 1.
- req_rs2  in  LENGTH  operand 2.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_rd  out  LENGTH  parallel result.
- alu_rs1_d  out  1  serial operand-1 bit.
- alu_rs2_d  out  1  serial operand-2 bit.
- alu_op  out  4  latched op code.
- alu_q  out  2  latched Q.
- count  out  CNT_W  cycle index to the ALU.
- reg_write  out  1  carry-update enable to the ALU.
- alu_rd_d  in  1  serial result bit from the ALU (combinational in the ALU).

Behaviour:
- Reset values:
  - State IDLE; count 0; reg_write 0.
  - alu_rs1_d, alu_rs2_d 0; alu_op 0; alu_q 0.
  - rsp_valid 0; rsp_rd 0; req_ready 1 after reset deasserts.
- Handshake:
  - A request is accepted on a clock edge with req_valid & req_ready.
  - On acceptance, latch rs1, rs2, op and Q into shift/config registers.
  - A response completes on a clock edge with rsp_valid & rsp_ready.
- FSM and cycle timing (count is a registered output; values below are what the ALU sees):
  - IDLE: count 0, reg_write 0, req_ready 1. Acceptance -> CLR.
  - CLR: one cycle. count 0, so the ALU clears its carry. reg_write 0. Bit outputs 0. -> PRE.
  - PRE: one cycle. count 1, reg_write 0. alu_rs1_d = rs1[LENGTH-1], the sign bit used by op 10 for positivity. alu_rs2_d = rs2[LENGTH-1]. No result capture. -> RUN.
  - RUN: counts 2..LENGTH+1, reg_write 1.
    - At count k, present rs1[k-2] and rs2[k-2].
    - On the edge ending each RUN cycle, shift alu_rd_d into the MSB of the result register (shift right).
    - After count LENGTH+1 the result register holds bit i = serial bit i. -> DONE.
  - DONE: rsp_valid 1; rsp_rd stable; count held at LENGTH+1; reg_write 0. On rsp_ready -> IDLE, rsp_valid 0.
- Latency: request accept to rsp_valid = LENGTH+2 cycles. Total occupancy is LENGTH+3 cycles minimum, including the DONE/IDLE cycle.
- Throughput: no request is accepted in the same cycle as a response completes; a new request is accepted in IDLE only.
- Operand stability: operands are shifted from the latched copies. req_* may change after acceptance.
- Backpressure: with rsp_ready low, DONE holds indefinitely and all ALU-side outputs stay static.
- Count encoding:
  - count is never 66 and never exceeds LENGTH+1.
  - It increments by exactly 1 per cycle from CLR through the end of RUN.
- Reset mid-operation: immediate return to IDLE with reset values. A partial result is discarded and no rsp_valid is issued.

Optional Feature:
- Macro: SEQ_ZERO_FLAG_EN.
- Defined:
  - Adds output rsp_zero (1 bit), valid with rsp_valid.
  - rsp_zero = 1 iff every captured rd bit was 0, tracked serially as an OR of captured bits, cleared in CLR.
  - Reset value 0.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Shared package serial_alu_pkg holds:
  - op-code constants: OP_ADD=0, OP_SUB=1, OP_QSEL=2, OP_RELU=10;
  - state enum: IDLE, CLR, PRE, RUN, DONE;
  - CNT_CLR=0 and CNT_SIGN=1.
- One sub-module, serial_operand_shifter: parallel-load, LSB-first shift register, instantiated twice for rs1 and rs2. It has a peek-MSB output for the PRE cycle.
- The result collector stays inline.

Test Plan:
- LENGTH=8, op 0, rs1=8'h05, rs2=8'h03 -> count trace 0,1,2..9; reg_write high exactly 8 cycles; rsp_rd=8'h08; rsp_valid on cycle 10 after accept.
- op 10, rs1=8'h25 -> rsp_rd=8'h25. op 10, rs1=8'h85 -> rsp_rd=8'h00. Checks the PRE-cycle sign bit.
- op 2, Q=2'b00, rs1=8'hA7, rs2=8'h3C -> rsp_rd=8'hA7. op 2, Q=2'b10, same operands -> result matches the ALU reference model.
- rsp_ready held low 3 cycles in DONE -> rsp_valid/rsp_rd stable, req_ready 0, second req_valid not accepted until after the response handshake.
- Assert reset at count 5 of an op -> same-cycle return to reset values with no rsp_valid. A following request rs1=8'h01, rs2=8'h01 -> 8'h02.
- SEQ_ZERO_FLAG_EN defined: add 8'hFF+8'h01 -> rsp_rd=8'h00, rsp_zero=1. Add 8'h01+8'h01 -> rsp_zero=0.
